// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for the 0xF00000xx window: HEX/LED registers,
// seven-segment decode, and synchronized/debounced KEY and synchronized SW readback.
module mmio_responder #(
    parameter int unsigned       DBITS           = 32,
    parameter logic [DBITS-1:0]  BASE_ADDR       = 32'hF0000000,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter int unsigned       DEB_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [DBITS-1:0] bus_addr,
    input  logic [DBITS-1:0] bus_wdata,
    output logic [DBITS-1:0] bus_rdata,
    output logic             bus_ack,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    logic [15:0]         hex_reg;
    logic [3:0]          key_s1, key_s2, key_stable;
    logic [9:0]          sw_s1, sw_s2;
    logic [DEB_BITS-1:0] deb_cnt [4];
    logic                sel;
    logic [5:0]          word_off;
    logic [DBITS-1:0]    read_val;
    logic                unused_bits;

    assign sel         = bus_req && (bus_addr[DBITS-1:8] == BASE_ADDR[DBITS-1:8]);
    assign word_off    = bus_addr[7:2];
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[DBITS-1:16]};

    always_comb begin
        read_val = '0;
        case (word_off)
            6'd0: read_val[15:0] = hex_reg;
            6'd1: read_val[9:0]  = LEDR;
            6'd2: read_val[7:0]  = LEDG;
            6'd4: read_val[3:0]  = ~key_stable;
            6'd5: read_val[9:0]  = sw_s2;
            default: read_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_reg   <= '0;
            LEDR      <= '0;
            LEDG      <= '0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= sel;
            bus_rdata <= '0;
            if (sel) begin
                if (bus_we) begin
                    case (word_off)
                        6'd0: hex_reg <= bus_wdata[15:0];
                        6'd1: LEDR    <= bus_wdata[9:0];
                        6'd2: LEDG    <= bus_wdata[7:0];
                        default: ;
                    endcase
                end else begin
                    bus_rdata <= read_val;
                end
            end
        end
    end

    // The stable bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1     <= '1;
            key_s2     <= '1;
            key_stable <= '1;
            sw_s1      <= '0;
            sw_s2      <= '0;
            for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (key_s2[i] != key_stable[i]) begin
                    if (deb_cnt[i] == DEB_BITS'(DEBOUNCE_CYCLES - 1)) begin
                        key_stable[i] <= key_s2[i];
                        deb_cnt[i]    <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        HEX0 = seg(hex_reg[3:0]);
        HEX1 = seg(hex_reg[7:4]);
        HEX2 = seg(hex_reg[11:8]);
        HEX3 = seg(hex_reg[15:12]);
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_responder #(
        .DBITS(32), .BASE_ADDR(32'hF0000000), .DEBOUNCE_CYCLES(16), .DEB_BITS(20)
    ) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each access starts 1 time unit after a posedge and returns 1 after the next.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_ack, input logic [31:0] exp_rdata, input string tag);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0;
        chk({tag, ".ack"}, {31'b0, bus_ack}, {31'b0, exp_ack});
        chk({tag, ".rdata"}, bus_rdata, exp_rdata);
    endtask

    task automatic idle(input string tag);
        @(posedge clk); #1;
        chk({tag, ".ack"}, {31'b0, bus_ack}, 32'h0);
    endtask

    initial begin
        #12;
        chk("rst.hex", {4'b0, HEX3, HEX2, HEX1, HEX0}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
        chk("rst.led", {14'b0, LEDR, LEDG}, 32'h0);
        chk("rst.ack", {31'b0, bus_ack}, 32'h0);
        chk("rst.rdata", bus_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        access(1'b1, 32'hF0000000, 32'h0000BEEF, 1'b1, 32'h0, "st_hex");
        chk("hex_seg", {4'b0, HEX3, HEX2, HEX1, HEX0}, {4'b0, 7'h03, 7'h06, 7'h06, 7'h0E});
        access(1'b0, 32'hF0000000, 32'h0, 1'b1, 32'h0000BEEF, "ld_hex");
        idle("idle1");

        access(1'b1, 32'hF0000004, 32'hFFFFFFFF, 1'b1, 32'h0, "st_ledr");
        access(1'b1, 32'hF0000008, 32'hFFFFFFFF, 1'b1, 32'h0, "st_ledg");
        chk("ledr", {22'b0, LEDR}, 32'h3FF);
        chk("ledg", {24'b0, LEDG}, 32'hFF);
        access(1'b0, 32'hF0000004, 32'h0, 1'b1, 32'h3FF, "ld_ledr");
        access(1'b0, 32'hF0000009, 32'h0, 1'b1, 32'hFF, "ld_ledg_lowbits");
        idle("idle2");

        access(1'b1, 32'hF0000000, 32'h12345678, 1'b1, 32'h0, "st_hex2");
        access(1'b0, 32'hF0000000, 32'h0, 1'b1, 32'h5678, "ld_hex2");

        // KEY0 pressed right after edge E0; stable updates at E18.
        KEY = 4'b1110;
        repeat (17) @(posedge clk);
        #1;
        access(1'b0, 32'hF0000010, 32'h0, 1'b1, 32'h0, "key_e18");
        access(1'b0, 32'hF0000010, 32'h0, 1'b1, 32'h1, "key_e19");

        KEY = 4'b1100;
        repeat (10) @(posedge clk);
        #1;
        KEY = 4'b1110;
        repeat (30) @(posedge clk);
        #1;
        access(1'b0, 32'hF0000010, 32'h0, 1'b1, 32'h1, "key_glitch");

        SW = 10'h2A5;
        repeat (2) @(posedge clk);
        #1;
        access(1'b0, 32'hF0000014, 32'h0, 1'b1, 32'h2A5, "ld_sw");
        access(1'b0, 32'hF000000C, 32'h0, 1'b1, 32'h0, "ld_unmapped");
        access(1'b1, 32'hF0000010, 32'hFFFFFFFF, 1'b1, 32'h0, "st_key");
        access(1'b1, 32'hF0000014, 32'hFFFFFFFF, 1'b1, 32'h0, "st_sw");
        access(1'b0, 32'hF0000010, 32'h0, 1'b1, 32'h1, "ld_key_after_st");
        access(1'b0, 32'hF0000014, 32'h0, 1'b1, 32'h2A5, "ld_sw_after_st");

        access(1'b1, 32'h00000040, 32'h0, 1'b0, 32'h0, "out_win_st");
        access(1'b1, 32'hF0010004, 32'h0, 1'b0, 32'h0, "near_win_st");
        chk("led_unchanged", {14'b0, LEDR, LEDG}, {14'b0, 10'h3FF, 8'hFF});

        access(1'b1, 32'hF0000008, 32'h00000055, 1'b1, 32'h0, "st_ledg55");
        chk("ledg55", {24'b0, LEDG}, 32'h55);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'hF0000008;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst.ledg", {24'b0, LEDG}, 32'h0);
        chk("arst.hex0", {25'b0, HEX0}, 32'h40);
        chk("arst.ack", {31'b0, bus_ack}, 32'h0);
        chk("arst.rdata", bus_rdata, 32'h0);
        bus_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle("post_rst1");
        idle("post_rst2");
        chk("post_rst.ledr", {22'b0, LEDR}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the processor data bus.
- Answers CPU loads and stores in the window 0xF0000000–0xF00000FF.
- Holds the HEX, LEDR and LEDG output registers and drives the four seven-segment displays.
- Synchronizes and debounces KEY, synchronizes SW, and returns both on reads.
- The CPU data path is the initiator; this block is the far end of that interface.

Parameters:
- DBITS, 32, bus data and address width.
- BASE_ADDR, 32'hF0000000, base of the I/O window. Bits [31:8] select this block.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a KEY bit changes. The board build overrides this to 500000.
- DEB_BITS, 20, debounce counter width. Requires DEBOUNCE_CYCLES < 2^DEB_BITS.

Ports:
- clk  in  1  system clock (PLL output)
- reset  in  1  asynchronous, active-low reset
- bus_req  in  1  access request, sampled at posedge clk
- bus_we  in  1  1 = store, 0 = load; qualified by bus_req
- bus_addr  in  DBITS  byte address
- bus_wdata  in  DBITS  store data
- bus_rdata  out  DBITS  load data; valid only while bus_ack=1, otherwise 0
- bus_ack  out  1  one-cycle response strobe
- KEY  in  4  raw pushbuttons, active-low, asynchronous
- SW  in  10  raw switches, asynchronous
- LEDR  out  10  red LEDs
- LEDG  out  8  green LEDs
- HEX0..HEX3  out  7 each  seven-segment outputs, active-low, bit order gfedcba

Behaviour:
Address map (offsets from BASE_ADDR):
- 0x00 HEX, R/W, bits [15:0].
- 0x04 LEDR, R/W, bits [9:0].
- 0x08 LEDG, R/W, bits [7:0].
- 0x10 KEY, read-only.
- 0x14 SW, read-only.

Selection:
- sel = bus_req & (bus_addr[31:8] == BASE_ADDR[31:8]).
- When sel=0: no ack, no state change; another responder owns that address.

Handshake and latency:
- A request sampled with sel=1 at edge N produces bus_ack=1 during cycle N+1, for exactly one cycle.
- bus_rdata is registered at edge N and presented during that same ack cycle.
- Back-to-back requests on consecutive edges are legal and produce consecutive acks.
- No wait states and no backpressure.

Stores:
- The target register updates at edge N.
- HEX takes wdata[15:0], LEDR takes wdata[9:0], LEDG takes wdata[7:0]. Upper bits are ignored.
- Stores to KEY, SW or an unmapped offset are acked and dropped.
- bus_rdata is 0 on a store ack.

Loads:
- Return the zero-extended register value.
- A load of a register in the cycle after a store to it returns the new value.
- Unmapped offsets return 0 and are still acked.
- bus_addr[1:0] is ignored: word access only.

KEY path:
- 2-flop synchronizer per bit, then a per-bit debounce counter.
- If the synchronized bit differs from the stable bit, the counter increments. When it reaches DEBOUNCE_CYCLES-1 the stable bit takes the synchronized value and the counter clears.
- If the synchronized bit equals the stable bit, the counter clears.
- A bounce shorter than DEBOUNCE_CYCLES never changes the stable bit.
- A KEY read returns {28'b0, ~stable}, so 1 = pressed.
- Total latency from a raw edge to the readable value is 2 + DEBOUNCE_CYCLES cycles.

SW path:
- 2-flop synchronizer, no debounce.
- A SW read returns {22'b0, sw_sync}. Latency is 2 cycles.

Displays:
- HEXk = segdecode(hex_reg[4k+3:4k]), combinational from the register.
- Table 0-F (hex values, active-low): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.

LED outputs:
- LEDR and LEDG drive their registers directly.

Reset (asynchronous, reset=0):
- hex_reg=0, so every HEXk = 7'h40 (shows "0000").
- LEDR=0, LEDG=0, bus_ack=0, bus_rdata=0.
- Synchronizers: KEY stages = 4'b1111, SW stages = 0.
- KEY stable=4'b1111, debounce counters=0.
- A request in flight when reset asserts is discarded; no ack is produced after reset releases.
- The first request can be sampled on the first posedge with reset=1.

Test Plan:
- Reset, then store 0x0000BEEF to 0xF0000000 → ack 1 cycle later with rdata=0. HEX3..HEX0 = 03,06,06,0E. A load of 0xF0000000 returns 0x0000BEEF.
- Store 0xFFFFFFFF to 0xF0000004 then to 0xF0000008 on back-to-back cycles → two consecutive acks. LEDR=0x3FF, LEDG=0xFF. Loads return 0x3FF and 0xFF.
- Hold KEY=4'b1110 steady, DEBOUNCE_CYCLES=16 → KEY reads 0x0 until 18 cycles after the edge, then 0x1. A 10-cycle glitch on KEY[1] never sets bit 1.
- Set SW=0x2A5, wait 2 cycles, load 0xF0000014 → rdata 0x000002A5. Load 0xF000000C → ack with rdata=0. Store to 0xF0000010 → acked, no state change.
- Request to 0x00000040 (outside the window) → no ack, LEDs unchanged.
- Write LEDG=0x55, then assert reset asynchronously mid-cycle with a pending load → LEDG=0, HEX=7'h40 immediately, no ack after release.
